// File: rtl/led_panel_pkg.sv
// Shared types and constants for the HUB75 LED panel scan driver.
// Address layout is {pad, row[4:0], col[5:0]}.
package led_panel_pkg;

  localparam int PANEL_COLS = 64;
  localparam int PANEL_ROWS = 32;
  localparam int SCAN_ROWS  = 16;

  localparam int ADDR_W  = 12;
  localparam int COL_LSB = 0;
  localparam int COL_W   = 6;
  localparam int ROW_LSB = 6;
  localparam int ROW_W   = 5;
  localparam int PAD_BIT = 11;

  typedef enum logic [2:0] {
    FETCH_TOP,
    FETCH_BOT,
    SETUP,
    CLK_HIGH,
    LATCH,
    DISPLAY
  } scan_state_e;

  function automatic logic [ADDR_W-1:0] make_addr(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ROW_LSB +: ROW_W] = row;
    a[COL_LSB +: COL_W] = col;
    a[PAD_BIT] = 1'b0;
    return a;
  endfunction

  // Pick bit idx of each 8-bit channel, returned as {R, G, B}.
  function automatic logic [2:0] plane_rgb(
    input logic [23:0] px,
    input logic [2:0]  idx
  );
    logic [23:0] s;
    s = px >> idx;
    return {s[16], s[8], s[0]};
  endfunction

endpackage

// File: rtl/bcm_plane_timer.sv
// Binary-code-modulation display timer: loads a tick count and
// raises done on the last cycle of the countdown.
module bcm_plane_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] ticks_i,
  output logic          done_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = ticks_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TW'(1));

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan driver for a 64x32 panel with per-row
// binary-code-modulation bitplanes.
module hub75_scan_driver
  import led_panel_pkg::*;
#(
  parameter int CLK_HALF   = 2,
  parameter int LAT_CYCLES = 2,
  parameter int BASE_TICKS = 64,
  parameter int PWM_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] pixel_addr,
  input  logic [23:0] pixel_data,
  output logic        r0,
  output logic        g0,
  output logic        b0,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic [3:0]  row_sel,
  output logic        panel_clk,
  output logic        lat,
  output logic        oe_n,
  output logic        frame_start
);

  localparam int PW = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam int TW = $clog2((BASE_TICKS << (PWM_BITS - 1)) + 1);
  localparam int PH_MAX = (CLK_HALF > LAT_CYCLES) ? CLK_HALF : LAT_CYCLES;
  localparam int CW = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int RW = $clog2(SCAN_ROWS);

  localparam logic [CW-1:0]    HALF_LAST = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0]    LAT_LAST  = CW'(LAT_CYCLES - 1);
  localparam logic [PW-1:0]    P_LAST    = PW'(PWM_BITS - 1);
  localparam logic [2:0]       IDX_BASE  = 3'(8 - PWM_BITS);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(PANEL_COLS - 1);
  localparam logic [ROW_W-1:0] BOT_OFS   = ROW_W'(PANEL_ROWS / 2);

  scan_state_e       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [PW-1:0]     plane_q, plane_d;
  logic [CW-1:0]     ph_q, ph_d;
  logic [2:0]        top_q, top_d;
  logic [5:0]        rgb_q, rgb_d;
  logic [RW-1:0]     row_sel_q, row_sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-1:0] addr_top, addr_bot, addr_c;
  logic [2:0]        bit_idx;
  logic [TW-1:0]     ticks;
  logic              tmr_load;
  logic              tmr_done;

  assign bit_idx  = IDX_BASE + 3'(plane_q);
  assign ticks    = TW'(BASE_TICKS) << plane_q;
  assign addr_top = make_addr(ROW_W'(row_q), col_q);
  assign addr_bot = make_addr(ROW_W'(row_q) + BOT_OFS, col_q);

  bcm_plane_timer #(
    .TW(TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .ticks_i(ticks),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    plane_d   = plane_q;
    ph_d      = ph_q;
    top_d     = top_q;
    rgb_d     = rgb_q;
    row_sel_d = row_sel_q;
    addr_c    = addr_q;
    tmr_load  = 1'b0;
    unique case (state_q)
      FETCH_TOP: begin
        addr_c  = addr_top;
        state_d = FETCH_BOT;
      end
      FETCH_BOT: begin
        addr_c  = addr_bot;
        top_d   = plane_rgb(pixel_data, bit_idx);
        ph_d    = '0;
        state_d = SETUP;
      end
      SETUP: begin
        // Lower pixel arrives one cycle after its address.
        if (ph_q == '0) begin
          rgb_d = {top_q, plane_rgb(pixel_data, bit_idx)};
        end
        if (ph_q == HALF_LAST) begin
          ph_d    = '0;
          state_d = CLK_HIGH;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      CLK_HIGH: begin
        if (ph_q == HALF_LAST) begin
          ph_d  = '0;
          col_d = col_q + 1'b1;
          if (col_q == COL_LAST) begin
            row_sel_d = row_q;
            state_d   = LATCH;
          end else begin
            state_d = FETCH_TOP;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      LATCH: begin
        if (ph_q == LAT_LAST) begin
          tmr_load = 1'b1;
          state_d  = DISPLAY;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      DISPLAY: begin
        if (tmr_done) begin
          state_d = FETCH_TOP;
          if (plane_q == P_LAST) begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end
      end
      default: state_d = FETCH_TOP;
    endcase
    addr_d = addr_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_TOP;
      col_q     <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      ph_q      <= '0;
      top_q     <= '0;
      rgb_q     <= '0;
      row_sel_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      ph_q      <= ph_d;
      top_q     <= top_d;
      rgb_q     <= rgb_d;
      row_sel_q <= row_sel_d;
      addr_q    <= addr_d;
    end
  end

  assign pixel_addr = addr_c;
  assign {r0, g0, b0, r1, g1, b1} = rgb_q;
  assign row_sel   = row_sel_q;
  assign panel_clk = (state_q == CLK_HIGH);
  assign lat       = (state_q == LATCH);
  assign oe_n      = (state_q != DISPLAY);
  assign frame_start = !rst && (state_q == FETCH_TOP) &&
                       (row_q == '0) && (plane_q == '0) &&
                       (col_q == '0);

endmodule

// File: doc/hub75_scan_driver.md
HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

Interface
REQ-001 SHALL have parameter CLK_HALF, default 2: system cycles per panel_clk phase (low and high).
REQ-002 SHALL have parameter LAT_CYCLES, default 2: lat high width in cycles.
REQ-003 SHALL have parameter BASE_TICKS, default 64: display cycles for bitplane 0.
REQ-004 SHALL have parameter PWM_BITS, default 4: bitplanes per row, using channel bits [7:8-PWM_BITS].
REQ-005 SHALL have ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pixel_addr  out  12  pixel request, {1'b0, ROW[4:0], COL[5:0]}
- pixel_data  in  24  {R[7:0],G[7:0],B[7:0]} for the address presented on the previous cycle
- r0/g0/b0  out  1 each  upper-half colour bits
- r1/g1/b1  out  1 each  lower-half colour bits
- row_sel  out  4  panel A-D address
- panel_clk  out  1  panel shift clock
- lat  out  1  panel latch
- oe_n  out  1  panel output enable, active-low
- frame_start  out  1  one-cycle pulse

Function
REQ-006 SHALL scan a 64x32 panel at 1/16: scan row r (0..15) drives upper row r and lower row r+16.
REQ-007 SHALL use states FETCH_TOP, FETCH_BOT, SETUP, CLK_HIGH, LATCH, DISPLAY.
REQ-008 FETCH_TOP (1 cycle) SHALL present pixel_addr = {1'b0, r, col}.
REQ-009 FETCH_BOT (1 cycle) SHALL capture the upper pixel's plane bits and present pixel_addr = {1'b0, r+16, col}.
REQ-010 On entering SETUP, the driver SHALL capture the lower pixel's plane bits and drive r0..b1 from the captured bits, with panel_clk=0, for CLK_HALF cycles.
REQ-011 CLK_HIGH SHALL drive panel_clk=1 for CLK_HALF cycles with r0..b1 stable.
- Exit to FETCH_TOP with col+1 when col<63.
- Exit to LATCH when col==63.
REQ-012 Plane colour bit for bitplane p SHALL be channel[8-PWM_BITS+p], evaluated per channel.
REQ-013 oe_n SHALL be 1 in every state except DISPLAY; shifting never overlaps display.
REQ-014 LATCH SHALL:
- update row_sel to r on entry;
- hold lat=1 for LAT_CYCLES cycles, with panel_clk=0.
REQ-015 DISPLAY SHALL hold oe_n=0 for exactly BASE_TICKS<<p cycles, then:
- if p<PWM_BITS-1, increment p and go to FETCH_TOP with col=0;
- otherwise set p=0, increment r (15 wraps to 0), and go to FETCH_TOP with col=0.
REQ-016 frame_start SHALL pulse on the first FETCH_TOP cycle of r=0, p=0, including the first one after reset.
REQ-017 Counters SHALL be sized exactly: col 6 bits, r 4 bits, p ceil(log2(PWM_BITS)) bits, display timer wide enough for BASE_TICKS<<(PWM_BITS-1).
REQ-018 pixel_addr bit 11 SHALL always be 0.
REQ-019 pixel_addr SHALL hold its last value outside FETCH states.

Reset
REQ-020 While rst is high, outputs SHALL be: pixel_addr=0, r0..b1=0, row_sel=0, panel_clk=0, lat=0, oe_n=1, frame_start=0.
REQ-021 While rst is high, state SHALL be FETCH_TOP with r=0, p=0, col=0.
REQ-022 Reset asserted mid-operation (any state) SHALL force the REQ-020 values asynchronously; scanning restarts from row 0, column 0, plane 0 after release.

Structure
REQ-023 A shared package led_panel_pkg SHALL hold:
- the state enum;
- PANEL_COLS=64, PANEL_ROWS=32, SCAN_ROWS=16;
- the pixel_addr field positions.
REQ-024 The display-time countdown SHALL be a sub-module bcm_plane_timer (load BASE_TICKS<<p, done pulse); all other logic is in hub75_scan_driver.

Verification
REQ-025 Release reset with pixel_data=24'h000000 -> pixel_addr=0x000, then 0x400, then 0x001; frame_start high on the first cycle; oe_n=1 until the first DISPLAY.
REQ-026 Constant pixel_data=24'hFF0000 -> exactly 64 panel_clk rising edges per lat pulse; r0=r1=1 and g/b=0 at every edge; lat high for 2 cycles.
REQ-027 Constant pixel_data=24'h800000 -> r0=1 only in plane 3; oe_n low for 64, 128, 256 and 512 cycles in planes 0..3.
REQ-028 Model returning distinct values per address -> captured upper and lower bits match rows r and r+16 at every column; row 16 column 5 requested as 0x405.
REQ-029 Run a full frame -> row_sel steps 0..15 then wraps to 0; frame_start pulses once per 16x4 latch sequences.
REQ-030 Assert rst during CLK_HIGH at col=30 -> all outputs take reset values before the next clk edge; after release, pixel_addr=0x000 and frame_start pulses.
